rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two sources.
  - In-order pipeline writeback (WB): high priority.
  - Multi-cycle mul/div unit (MDU): buffered results, valid/ready handshake.
- Keeps a 32-bit scoreboard of registers with an outstanding MDU result, so issue logic can interlock.
- Sits between the WB stage / MDU and the register file; its registered outputs drive the register file's wr/addr3/data3 inputs directly.

Parameters:
- FIFO_DEPTH, 2: MDU result buffer entries (power of two, >=2).
- STARVE_LIMIT, 4: consecutive WB grants with a non-empty buffer before the buffer is forced through (>=1).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- wb_valid  input  1  pipeline WB has a write this cycle.
- wb_addr  input  5  WB destination register.
- wb_data  input  32  WB write data.
- wb_stall  output  1  WB not granted this cycle; pipeline holds wb_* stable.
- mdu_issue  input  1  MDU operation issued this cycle.
- mdu_issue_addr  input  5  destination register of the issued MDU op.
- mdu_valid  input  1  MDU result available.
- mdu_ready  output  1  buffer can accept a result.
- mdu_addr  input  5  MDU result destination.
- mdu_data  input  32  MDU result data.
- rf_wr  output  1  register-file write enable.
- rf_addr  output  5  register-file write address.
- rf_data  output  32  register-file write data.
- busy  output  32  per-register outstanding-MDU-result flags.

Behaviour:
- Reset (async, high):
  - Buffer emptied; starve_cnt=0; busy=0.
  - rf_wr=0, rf_addr=0, rf_data=0.
  - While reset is high: mdu_ready=0 and wb_stall=0.
- Buffer:
  - FIFO of {addr,data}, FIFO_DEPTH entries.
  - mdu_ready = !reset & !full. Full is evaluated from current state; a pop in the same cycle does not enable a push.
  - Push on mdu_valid & mdu_ready. There is no bypass: a pushed entry is grantable from the next cycle at the earliest.
- Grant, combinational each cycle, where force = (starve_cnt == STARVE_LIMIT):
  - If buffer non-empty & (force | !wb_valid): grant the buffer head and pop it.
  - Else if wb_valid: grant WB.
  - Else: no grant.
- wb_stall = wb_valid & buffer non-empty & force.
- starve_cnt:
  - Cleared when the buffer head is granted or the buffer is empty.
  - Incremented (saturating at STARVE_LIMIT) when WB is granted while the buffer is non-empty.
- Output register, one cycle after grant:
  - rf_wr <= granted & (granted addr != 0).
  - rf_addr/rf_data <= granted addr/data when granted; otherwise held.
- Writes to $0 from either source are consumed (popped / not stalled) but produce rf_wr=0.
- Latency: WB write to rf_wr is 1 cycle. MDU accept to rf_wr is 2 cycles minimum.
- Scoreboard:
  - busy[a] set at the posedge where mdu_issue=1 and a=mdu_issue_addr, a!=0.
  - busy[a] cleared at the posedge where the buffer head with addr a is granted.
  - Simultaneous set and clear of the same bit: set wins.
  - busy[0] is always 0.
  - Issue logic never issues to a register with busy=1; the bench checks this with an assertion.
- Reset asserted mid-operation discards buffered results and all busy flags immediately.

Test Plan:
- Reset released, wb_valid=1, wb_addr=5, wb_data=32'hA5A5_0001 -> next cycle rf_wr=1, rf_addr=5, rf_data=32'hA5A5_0001; wb_stall=0 throughout.
- mdu_issue to r9, then mdu_valid r9=32'h1234 with WB idle -> busy[9]=1 from the issue edge; rf_wr r9 exactly 2 cycles after accept; busy[9] clears on the grant edge.
- Buffer holds one entry, wb_valid held continuously:
  - WB granted for 4 consecutive cycles.
  - 5th cycle: wb_stall=1 and the buffer head is written.
  - starve_cnt returns to 0; the WB write lands the following cycle.
- wb_valid held, MDU pushes 3 results (DEPTH=2) -> mdu_ready=0 after 2 accepts; the 3rd is held until the first forced pop, then accepted the following cycle, never the pop cycle.
- WB write to r0 and MDU result to r0 -> both consumed, rf_wr stays 0, busy[0] stays 0.
- Reset pulsed with 2 buffered entries and busy[3]=1 -> rf_wr=0, mdu_ready=0 and busy=0 immediately; no stale write after release.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: in-order writeback has priority, buffered
// mul/div results fill idle slots or are forced through after a starvation limit.
module rf_wb_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_addr,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        rf_wr,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic [31:0] busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    buf_addr [FIFO_DEPTH];
    logic [31:0]   buf_data [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [SW-1:0] starve_cnt;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          force_buf;
    logic          grant_wb;
    logic          granted;
    logic [4:0]    grant_addr;
    logic [31:0]   grant_data;
    logic [31:0]   busy_set;
    logic [31:0]   busy_clr;

    // MDU handshake: a result transfers on a cycle where mdu_valid && mdu_ready;
    // mdu_ready depends only on current fullness, so a same-cycle pop never frees a slot.
    always_comb begin
        empty      = (count == '0);
        full       = (count == (AW+1)'(FIFO_DEPTH));
        force_buf  = (starve_cnt == SW'(STARVE_LIMIT));
        pop        = !empty && (force_buf || !wb_valid);
        grant_wb   = wb_valid && !pop;
        granted    = pop || grant_wb;
        grant_addr = wb_addr;
        grant_data = wb_data;
        if (pop) begin
            grant_addr = buf_addr[rd_ptr];
            grant_data = buf_data[rd_ptr];
        end
        mdu_ready = !reset && !full;
        push      = mdu_valid && mdu_ready;
        wb_stall  = !reset && wb_valid && !empty && force_buf;
        busy_set  = '0;
        busy_clr  = '0;
        if (mdu_issue) busy_set[mdu_issue_addr] = 1'b1;
        if (pop)       busy_clr[buf_addr[rd_ptr]] = 1'b1;
    end

    // Payload storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= mdu_addr;
            buf_data[wr_ptr] <= mdu_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            busy       <= '0;
            rf_wr      <= 1'b0;
            rf_addr    <= '0;
            rf_data    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);

            if (pop || empty)
                starve_cnt <= '0;
            else if (grant_wb && !force_buf)
                starve_cnt <= starve_cnt + 1'b1;

            // Set wins over a same-edge clear; r0 is never tracked.
            busy <= ((busy & ~busy_clr) | busy_set) & ~32'h1;

            rf_wr <= granted && (grant_addr != 5'd0);
            if (granted) begin
                rf_addr <= grant_addr;
                rf_data <= grant_data;
            end
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: writeback priority, starvation forcing,
// buffer back-pressure, r0 handling, scoreboard flags and mid-run reset.
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_addr;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        rf_wr;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [31:0] busy;

    int total = 0;
    int bad   = 0;

    rf_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
        .mdu_issue(mdu_issue), .mdu_issue_addr(mdu_issue_addr),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic wr, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_wr"}, {31'b0, rf_wr}, {31'b0, wr});
        chk({tag, "_addr"}, {27'b0, rf_addr}, {27'b0, a});
        chk({tag, "_data"}, rf_data, d);
    endtask

    initial begin
        reset = 1'b1;
        wb_valid = 0; wb_addr = 0; wb_data = 0;
        mdu_issue = 0; mdu_issue_addr = 0;
        mdu_valid = 0; mdu_addr = 0; mdu_data = 0;

        // Reset state
        tick(); tick();
        chk_out("rst", 1'b0, 5'd0, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_ready", {31'b0, mdu_ready}, 32'h0);
        chk("rst_stall", {31'b0, wb_stall}, 32'h0);
        reset = 1'b0;

        // Plain WB write, one cycle latency
        wb_valid = 1; wb_addr = 5; wb_data = 32'hA5A5_0001;
        #1;
        chk("t1_stall", {31'b0, wb_stall}, 32'h0);
        chk("t1_ready", {31'b0, mdu_ready}, 32'h1);
        tick();
        chk_out("t1", 1'b1, 5'd5, 32'hA5A5_0001);
        wb_valid = 0;

        // MDU issue/result to r9 with WB idle
        chk("t2_issue_free", {31'b0, busy[9]}, 32'h0);
        mdu_issue = 1; mdu_issue_addr = 9;
        tick();
        chk("t2_busy_set", busy, 32'h0000_0200);
        chk("t2_idle_wr", {31'b0, rf_wr}, 32'h0);
        mdu_issue = 0;
        mdu_valid = 1; mdu_addr = 9; mdu_data = 32'h1234;
        #1;
        chk("t2_ready", {31'b0, mdu_ready}, 32'h1);
        tick();
        mdu_valid = 0;
        chk("t2_wr_1cyc", {31'b0, rf_wr}, 32'h0);
        chk("t2_busy_hold", busy, 32'h0000_0200);
        tick();
        chk_out("t2", 1'b1, 5'd9, 32'h1234);
        chk("t2_busy_clr", busy, 32'h0);

        // Starvation: one buffered entry while WB writes every cycle
        chk("t3_issue_free", {31'b0, busy[7]}, 32'h0);
        mdu_issue = 1; mdu_issue_addr = 7;
        mdu_valid = 1; mdu_addr = 7; mdu_data = 32'h77;
        for (int i = 1; i <= 5; i++) begin
            wb_valid = 1; wb_addr = 5'(i); wb_data = 32'd100 + i;
            #1;
            chk("t3_no_stall", {31'b0, wb_stall}, 32'h0);
            tick();
            mdu_issue = 0; mdu_valid = 0;
            chk_out("t3_wb", 1'b1, 5'(i), 32'd100 + i);
        end
        chk("t3_busy7", busy, 32'h0000_0080);
        wb_addr = 6; wb_data = 32'd106;
        #1;
        chk("t3_stall", {31'b0, wb_stall}, 32'h1);
        tick();
        chk_out("t3_forced", 1'b1, 5'd7, 32'h77);
        chk("t3_busy_clr", busy, 32'h0);
        chk("t3_stall_drop", {31'b0, wb_stall}, 32'h0);
        tick();
        chk_out("t3_wb_after", 1'b1, 5'd6, 32'd106);
        wb_valid = 0;

        // Back-pressure: three results into a two-entry buffer under WB load
        wb_valid = 1; wb_addr = 20; wb_data = 32'h2014;
        mdu_valid = 1; mdu_addr = 11; mdu_data = 32'hB1;
        #1;
        chk("t4_ready0", {31'b0, mdu_ready}, 32'h1);
        tick();
        wb_addr = 21; wb_data = 32'h2015;
        mdu_addr = 12; mdu_data = 32'hB2;
        #1;
        chk("t4_ready1", {31'b0, mdu_ready}, 32'h1);
        tick();
        mdu_addr = 13; mdu_data = 32'hB3;
        for (int i = 22; i <= 24; i++) begin
            wb_addr = 5'(i); wb_data = 32'h2000 + i;
            #1;
            chk("t4_full", {31'b0, mdu_ready}, 32'h0);
            chk("t4_no_stall", {31'b0, wb_stall}, 32'h0);
            tick();
            chk_out("t4_wb", 1'b1, 5'(i), 32'h2000 + i);
        end
        wb_addr = 25; wb_data = 32'h2019;
        #1;
        chk("t4_pop_full", {31'b0, mdu_ready}, 32'h0);
        chk("t4_stall", {31'b0, wb_stall}, 32'h1);
        tick();
        chk_out("t4_forced", 1'b1, 5'd11, 32'hB1);
        chk("t4_ready_after", {31'b0, mdu_ready}, 32'h1);
        chk("t4_stall_drop", {31'b0, wb_stall}, 32'h0);
        tick();
        chk_out("t4_wb_held", 1'b1, 5'd25, 32'h2019);
        mdu_valid = 0; wb_valid = 0;
        tick();
        chk_out("t4_drain_b", 1'b1, 5'd12, 32'hB2);
        tick();
        chk_out("t4_drain_c", 1'b1, 5'd13, 32'hB3);
        tick();
        chk("t4_idle", {31'b0, rf_wr}, 32'h0);

        // Writes to r0 from both sources
        wb_valid = 1; wb_addr = 0; wb_data = 32'hDEAD_0000;
        mdu_issue = 1; mdu_issue_addr = 0;
        mdu_valid = 1; mdu_addr = 0; mdu_data = 32'hBEEF_0000;
        #1;
        chk("t5_stall", {31'b0, wb_stall}, 32'h0);
        tick();
        wb_valid = 0; mdu_valid = 0; mdu_issue = 0;
        chk_out("t5_wb_r0", 1'b0, 5'd0, 32'hDEAD_0000);
        chk("t5_busy", busy, 32'h0);
        tick();
        chk_out("t5_mdu_r0", 1'b0, 5'd0, 32'hBEEF_0000);
        chk("t5_busy2", busy, 32'h0);

        // Reset mid-operation with two buffered entries and busy[3]
        chk("t6_issue_free", {31'b0, busy[3]}, 32'h0);
        wb_valid = 1; wb_addr = 1; wb_data = 32'h1111;
        mdu_issue = 1; mdu_issue_addr = 3;
        mdu_valid = 1; mdu_addr = 3; mdu_data = 32'h33;
        tick();
        mdu_issue = 0;
        wb_addr = 2; wb_data = 32'h2222;
        mdu_addr = 4; mdu_data = 32'h44;
        tick();
        mdu_valid = 0;
        chk("t6_busy3", busy, 32'h0000_0008);
        chk("t6_full", {31'b0, mdu_ready}, 32'h0);
        chk_out("t6_pre", 1'b1, 5'd2, 32'h2222);
        reset = 1; wb_valid = 0;
        #1;
        chk("t6_rst_wr", {31'b0, rf_wr}, 32'h0);
        chk("t6_rst_ready", {31'b0, mdu_ready}, 32'h0);
        chk("t6_rst_busy", busy, 32'h0);
        tick();
        reset = 0;
        #1;
        chk("t6_ready_rel", {31'b0, mdu_ready}, 32'h1);
        tick();
        chk("t6_no_stale1", {31'b0, rf_wr}, 32'h0);
        tick();
        chk("t6_no_stale2", {31'b0, rf_wr}, 32'h0);
        chk("t6_busy_final", busy, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
